// File: rtl/issue_dispatcher.sv
// rtl/issue_dispatcher.sv - pops the command issue FIFO and issues DRAM commands
// under per-bank (tRCD/tRAS/tRP) and global (tCCD/tRFC) timing, tracking open banks.
module issue_dispatcher #(
  parameter int CMD_W   = 4,
  parameter int ADDR_W  = 14,
  parameter int BANK_W  = 3,
  parameter int TIMER_W = 6,
  parameter int T_RCD   = 3,
  parameter int T_RAS   = 8,
  parameter int T_RP    = 3,
  parameter int T_CCD   = 2,
  parameter int T_RFC   = 12
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CMD_W+ADDR_W+BANK_W-1:0]   fifo_data,
  input  logic                             fifo_empty,
  output logic                             fifo_ren,
  input  logic                             issue_en,
  output logic [CMD_W-1:0]                 dram_cmd,
  output logic [ADDR_W-1:0]                dram_addr,
  output logic [BANK_W-1:0]                dram_bank,
  output logic                             dram_cmd_valid,
  output logic [(2**BANK_W)-1:0]           bank_open,
  output logic                             proto_err,
  output logic                             busy
);

  localparam int NUM_BANK = 2**BANK_W;
  localparam logic [CMD_W-1:0] C_ACT = CMD_W'(1);
  localparam logic [CMD_W-1:0] C_RD  = CMD_W'(2);
  localparam logic [CMD_W-1:0] C_WR  = CMD_W'(3);
  localparam logic [CMD_W-1:0] C_PRE = CMD_W'(4);
  localparam logic [CMD_W-1:0] C_REF = CMD_W'(5);

  typedef enum logic [1:0] {IDLE, WAIT, REF, ERR} state_t;

  state_t state_q, state_d;

  logic [TIMER_W-1:0] trcd_q [NUM_BANK];
  logic [TIMER_W-1:0] trcd_d [NUM_BANK];
  logic [TIMER_W-1:0] tras_q [NUM_BANK];
  logic [TIMER_W-1:0] tras_d [NUM_BANK];
  logic [TIMER_W-1:0] trp_q  [NUM_BANK];
  logic [TIMER_W-1:0] trp_d  [NUM_BANK];
  logic [TIMER_W-1:0] tccd_q, tccd_d;
  logic [TIMER_W-1:0] trfc_q, trfc_d;

  logic [NUM_BANK-1:0] bank_open_q, bank_open_d;
  logic                proto_err_q, proto_err_d;
  logic                busy_q, busy_d;
  logic [CMD_W-1:0]    dram_cmd_q, dram_cmd_d;
  logic [ADDR_W-1:0]   dram_addr_q, dram_addr_d;
  logic [BANK_W-1:0]   dram_bank_q, dram_bank_d;
  logic                dram_cmd_valid_q, dram_cmd_valid_d;

  logic [CMD_W-1:0]  head_cmd;
  logic [ADDR_W-1:0] head_addr;
  logic [BANK_W-1:0] head_bank;
  logic              head_ok;
  logic              legal;
  logic              violation;
  logic              violation_hit;
  logic              pop;
  logic              trp_all_zero;

  assign head_cmd  = fifo_data[CMD_W+ADDR_W+BANK_W-1 -: CMD_W];
  assign head_addr = fifo_data[BANK_W +: ADDR_W];
  assign head_bank = fifo_data[BANK_W-1:0];

  always_comb begin
    trp_all_zero = 1'b1;
    for (int i = 0; i < NUM_BANK; i++) begin
      if (trp_q[i] != '0) trp_all_zero = 1'b0;
    end

    legal     = 1'b1;
    violation = 1'b0;
    case (head_cmd)
      C_ACT: begin
        violation = bank_open_q[head_bank];
        legal     = ~bank_open_q[head_bank] && (trp_q[head_bank] == '0);
      end
      C_RD, C_WR: begin
        violation = ~bank_open_q[head_bank];
        legal     = bank_open_q[head_bank] && (trcd_q[head_bank] == '0) && (tccd_q == '0);
      end
      C_PRE: legal = (tras_q[head_bank] == '0);
      C_REF: begin
        violation = |bank_open_q;
        legal     = ~(|bank_open_q) && trp_all_zero;
      end
      default: legal = 1'b1;
    endcase
    legal = legal && (trfc_q == '0);

    // Violations are caught even while a timer blocks the entry.
    head_ok       = issue_en && ~fifo_empty && (state_q != ERR);
    violation_hit = head_ok && violation;
    pop           = rst_n && head_ok && legal && ~violation;
  end

  assign fifo_ren = pop;

  always_comb begin
    for (int i = 0; i < NUM_BANK; i++) begin
      trcd_d[i] = (trcd_q[i] != '0) ? trcd_q[i] - 1'b1 : '0;
      tras_d[i] = (tras_q[i] != '0) ? tras_q[i] - 1'b1 : '0;
      trp_d[i]  = (trp_q[i]  != '0) ? trp_q[i]  - 1'b1 : '0;
    end
    tccd_d      = (tccd_q != '0) ? tccd_q - 1'b1 : '0;
    trfc_d      = (trfc_q != '0) ? trfc_q - 1'b1 : '0;
    bank_open_d = bank_open_q;

    if (pop) begin
      case (head_cmd)
        C_ACT: begin
          bank_open_d[head_bank] = 1'b1;
          trcd_d[head_bank]      = TIMER_W'(T_RCD - 1);
          tras_d[head_bank]      = TIMER_W'(T_RAS - 1);
        end
        C_PRE: begin
          bank_open_d[head_bank] = 1'b0;
          trp_d[head_bank]       = TIMER_W'(T_RP - 1);
        end
        C_RD, C_WR: tccd_d = TIMER_W'(T_CCD - 1);
        C_REF:      trfc_d = TIMER_W'(T_RFC - 1);
        default: ;
      endcase
    end
  end

  always_comb begin
    dram_cmd_d       = dram_cmd_q;
    dram_addr_d      = dram_addr_q;
    dram_bank_d      = dram_bank_q;
    dram_cmd_valid_d = 1'b0;
    if (pop) begin
      dram_cmd_d       = head_cmd;
      dram_addr_d      = head_addr;
      dram_bank_d      = head_bank;
      dram_cmd_valid_d = (head_cmd >= C_ACT) && (head_cmd <= C_REF);
    end

    state_d = state_q;
    case (state_q)
      IDLE, WAIT: begin
        if (pop && head_cmd == C_REF) state_d = (T_RFC > 1) ? REF : IDLE;
        else if (head_ok && !pop)     state_d = WAIT;
        else                          state_d = IDLE;
      end
      REF:     if (trfc_d == '0) state_d = IDLE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if (violation_hit) state_d = ERR;

    proto_err_d = proto_err_q | violation_hit;
    // busy trails the state by one cycle so it covers the cycles after the issued pulse.
    busy_d      = (state_q == WAIT) || (state_q == REF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      for (int i = 0; i < NUM_BANK; i++) begin
        trcd_q[i] <= '0;
        tras_q[i] <= '0;
        trp_q[i]  <= '0;
      end
      tccd_q           <= '0;
      trfc_q           <= '0;
      bank_open_q      <= '0;
      proto_err_q      <= 1'b0;
      busy_q           <= 1'b0;
      dram_cmd_q       <= '0;
      dram_addr_q      <= '0;
      dram_bank_q      <= '0;
      dram_cmd_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      for (int i = 0; i < NUM_BANK; i++) begin
        trcd_q[i] <= trcd_d[i];
        tras_q[i] <= tras_d[i];
        trp_q[i]  <= trp_d[i];
      end
      tccd_q           <= tccd_d;
      trfc_q           <= trfc_d;
      bank_open_q      <= bank_open_d;
      proto_err_q      <= proto_err_d;
      busy_q           <= busy_d;
      dram_cmd_q       <= dram_cmd_d;
      dram_addr_q      <= dram_addr_d;
      dram_bank_q      <= dram_bank_d;
      dram_cmd_valid_q <= dram_cmd_valid_d;
    end
  end

  assign dram_cmd       = dram_cmd_q;
  assign dram_addr      = dram_addr_q;
  assign dram_bank      = dram_bank_q;
  assign dram_cmd_valid = dram_cmd_valid_q;
  assign bank_open      = bank_open_q;
  assign proto_err      = proto_err_q;
  assign busy           = busy_q;

endmodule

// File: doc/issue_dispatcher.md
# issue_dispatcher

Consumer end of the command issue FIFO. It pops pre-ordered {command, addr, bank} entries from the FIFO head and enforces per-bank and global DRAM timing (tRCD, tRAS, tRP, tCCD, tRFC). It drives one registered DRAM command per cycle toward the PHY and tracks the open/closed state of every bank. It sits between the command scheduler's issue FIFO and the PHY command port.

## Interface
- CMD_W, 4, command field width
- ADDR_W, 14, row/column address width
- BANK_W, 3, bank index width; NUM_BANK = 2**BANK_W
- TIMER_W, 6, timing counter width; every T_* must be in 1..2**TIMER_W-1
- T_RCD, 3, ACT to RD/WR on the same bank, in cycles between dram_cmd_valid pulses
- T_RAS, 8, ACT to PRE on the same bank
- T_RP, 3, PRE to ACT on the same bank
- T_CCD, 2, RD/WR to RD/WR on any bank
- T_RFC, 12, REF to any command
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- fifo_data  in  CMD_W+ADDR_W+BANK_W  FIFO head, packed {cmd, addr, bank}; bank is in the LSBs; show-ahead, valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO holds no entry
- fifo_ren  out  CMD_W... 1  pop request; combinational
- issue_en  in  1  global enable; while low, nothing is popped
- dram_cmd  out  CMD_W  registered command
- dram_addr  out  ADDR_W  registered address
- dram_bank  out  BANK_W  registered bank
- dram_cmd_valid  out  1  one-cycle pulse per issued command
- bank_open  out  NUM_BANK  per-bank open-row flag
- proto_err  out  1  sticky protocol-violation flag
- busy  out  1  high in the WAIT and REF states

## Operation
- Command encoding: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF. Codes 6–15 are illegal-but-harmless.
- State machine: IDLE, WAIT, REF, ERR.
  - IDLE: fifo_empty=1 or issue_en=0.
  - WAIT: a head entry is present but blocked by a timer.
  - REF: trfc_cnt is nonzero after a REF.
  - ERR: terminal until reset.
- Transitions:
  - IDLE→WAIT when the head is present and blocked.
  - WAIT→IDLE when the entry is issued and the FIFO empties.
  - Any state except ERR goes to REF on issuing a REF.
  - REF→IDLE or WAIT when trfc_cnt reaches 0.
  - Any state goes to ERR on a violation.
- Legality of the head entry:
  - ACT requires bank closed and trp_cnt[b]=0.
  - RD/WR require bank open, trcd_cnt[b]=0 and tccd_cnt=0.
  - PRE requires tras_cnt[b]=0. PRE to a closed bank is legal and is issued.
  - REF requires all banks closed and all trp_cnt=0.
  - Every command also requires trfc_cnt=0.
  - NOP and codes 6–15 are popped with no dram_cmd_valid.
- Violations (entry is not popped, proto_err is set, state goes to ERR): ACT to an open bank, RD/WR to a closed bank, REF with any bank open. In ERR, fifo_ren=0 forever.
- fifo_ren = issue_en & ~fifo_empty & legal & ~ERR & ~violation.
- On a pop edge:
  - The output registers load the entry; dram_cmd_valid=1 for NOP-class only if the code is 1–5.
  - ACT sets bank_open[b], loads trcd_cnt[b]=T_RCD-1 and tras_cnt[b]=T_RAS-1.
  - PRE clears bank_open[b] and loads trp_cnt[b]=T_RP-1.
  - RD/WR load tccd_cnt=T_CCD-1.
  - REF loads trfc_cnt=T_RFC-1.
- All counters are down-counters that saturate at 0 and decrement every cycle they are not loaded.

## Timing
- Reset values:
  - dram_cmd_valid=0, dram_cmd=0, dram_addr=0, dram_bank=0.
  - bank_open=0, proto_err=0, busy=0.
  - All counters 0; state IDLE.
  - fifo_ren=0 while rst_n=0.
- Latency: fifo_ren high in cycle t gives dram_* valid in cycle t+1. Back-to-back issue at one per cycle is possible.
- A dependent command with parameter T is issued with its dram_cmd_valid pulses exactly T cycles apart when the FIFO is never starved.
- issue_en falling has no effect on a command already popped. Timers keep running while issue_en=0.
- Reset mid-operation discards all bank and timer state. It does not pop the FIFO.
- If fifo_empty rises in the same cycle a timer expires, the dispatcher stays in IDLE with no pop.

## Test plan
- ACT b2 then RD b2, both queued at once → ACT valid at cycle c, RD valid at c+3, bank_open=8'h04.
- ACT b0, RD b0, RD b0, PRE b0, ACT b0 → RDs at c+3 and c+5, PRE at c+8, second ACT at c+11, bank_open ends 8'h01.
- ACT b1 then ACT b5 → valid on consecutive cycles c and c+1.
- REF with all banks closed, followed by ACT b0 → REF at c, ACT at c+12, busy high during c+1..c+11.
- RD b3 with bank 3 closed → no pop, proto_err=1, no further dram_cmd_valid even with more entries queued. A reset clears proto_err and bank_open to 0.
- issue_en=0 with 4 entries queued for 10 cycles → fifo_ren stays 0. After issue_en=1, the first pop occurs the same cycle.
